// File: rtl/addertree_final_cpa_pkg.sv
// Shared definitions for the final carry-propagate / accumulate / requantize stage.
// Holds the default widths and the signed-saturate and requantize functions.
// The functions work in a wide signed type so one definition serves every parameterisation.
package addertree_final_cpa_pkg;

    localparam int DEF_IN_W  = 19;  // redundant row width
    localparam int DEF_SPLIT = 10;  // low/high split of the carry-propagate adder
    localparam int DEF_ACC_W = 24;  // signed accumulator width
    localparam int DEF_OUT_W = 8;   // unsigned activation width
    localparam int SHIFT_W   = 5;   // requantization shift field width
    localparam int CALC_W    = 64;  // working width, wide enough that nothing here overflows

    typedef logic signed [CALC_W-1:0] calc_t;

    // Largest value representable in a w-bit two's complement number.
    function automatic calc_t smax(input int w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    // Clamp x into the signed w-bit range.
    function automatic calc_t sat_val(input calc_t x, input int w);
        calc_t hi;
        calc_t lo;
        calc_t r;
        hi = smax(w);
        lo = -hi - calc_t'(1);
        r  = x;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end
        return r;
    endfunction

    // 1 when x lies outside the signed w-bit range and sat_val had to clamp it.
    function automatic logic sat_hit(input calc_t x, input int w);
        calc_t hi;
        calc_t lo;
        hi = smax(w);
        lo = -hi - calc_t'(1);
        return (x > hi) || (x < lo);
    endfunction

    // Round-half-up arithmetic right shift, then ReLU and clamp to an out_w-bit
    // unsigned range. The rounding constant is added before shifting, in a type
    // wide enough that the add cannot wrap.
    function automatic calc_t requant(input calc_t acc, input logic [SHIFT_W-1:0] shift,
                                      input int out_w);
        calc_t rnd;
        calc_t r;
        calc_t top;
        rnd = '0;
        if (shift != '0) begin
            rnd = calc_t'(1) <<< (shift - 1'b1);
        end
        r   = (acc + rnd) >>> shift;
        top = (calc_t'(1) <<< out_w) - calc_t'(1);
        if (r < calc_t'(0)) begin
            r = '0;
        end else if (r > top) begin
            r = top;
        end
        return r;
    endfunction

endpackage

// File: rtl/addertree_requant.sv
// Combinational requantizer: round-half-up shift, ReLU, clamp to OUT_W unsigned.
// Latency: 0 cycles (pure combinational, registered by the parent).
// Backpressure: none; the parent holds i_acc/i_shift stable while stalled.
// Ports: i_acc (signed accumulator), i_shift (right shift), o_data (activation).
module addertree_requant
    import addertree_final_cpa_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic        [SHIFT_W-1:0] i_shift,
    output logic        [OUT_W-1:0]   o_data
);

    // requant() already guarantees the result fits in OUT_W unsigned bits,
    // so the truncating cast drops only zero bits.
    always_comb begin
        o_data = OUT_W'(requant(calc_t'(i_acc), i_shift, OUT_W));
    end

endmodule

// File: rtl/addertree_final_cpa.sv
// Final stage of the adder tree: split CPA over two cycles, multi-pass accumulate, requantize.
// Latency: last beat accepted in cycle N -> out_valid in cycle N+3; one beat per cycle throughput.
// Backpressure: stall = out_valid & ~out_ready freezes every stage and drops in_ready.
// Ports: row_a/row_b redundant rows with in_valid/in_last/in_ready; cfg_shift requant shift;
//        out_data/out_ovf with out_valid/out_ready; busy while anything is in flight or a group is open.
module addertree_final_cpa
    import addertree_final_cpa_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int SPLIT = DEF_SPLIT,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [IN_W-1:0]    row_a,
    input  logic [IN_W-1:0]    row_b,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic [SHIFT_W-1:0] cfg_shift,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int HI_W = IN_W - SPLIT;

    // ---------------------------------------------------------------
    // Flow control: the whole pipeline moves together or not at all.
    // ---------------------------------------------------------------
    logic w_stall;
    logic w_accept;

    // ---------------------------------------------------------------
    // S1: low half of the CPA plus carry, high slices passed through.
    // ---------------------------------------------------------------
    logic             r_s1_vld;
    logic             r_s1_last;
    logic [SPLIT-1:0] r_s1_lo;
    logic             r_s1_c;
    logic [HI_W-1:0]  r_s1_a_hi;
    logic [HI_W-1:0]  r_s1_b_hi;
    logic [SPLIT:0]   w_lo_full;

    // ---------------------------------------------------------------
    // S2: high half of the CPA, accumulate with saturation.
    // ---------------------------------------------------------------
    logic [HI_W-1:0]         w_hi;
    logic signed [IN_W-1:0]  w_sum;
    logic signed [ACC_W-1:0] w_sum_ext;
    calc_t                   w_acc_add;
    logic signed [ACC_W-1:0] w_acc_sat;
    logic                    w_sat_hit;

    logic                    r_s2_vld;     // a closed group's result sits in r_acc/r_ovf
    logic                    r_grp_open;   // a group has started and not yet seen its last beat
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;

    // ---------------------------------------------------------------
    // S3: requantize and present to the output buffer.
    // ---------------------------------------------------------------
    logic [OUT_W-1:0] w_q;
    logic             r_out_vld;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ovf;

    assign w_stall  = r_out_vld & ~out_ready;
    assign w_accept = in_valid & ~w_stall;
    assign in_ready = ~w_stall;

    // The extra MSB of w_lo_full is the carry into the high half.
    assign w_lo_full = {1'b0, row_a[SPLIT-1:0]} + {1'b0, row_b[SPLIT-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_lo   <= '0;
            r_s1_c    <= 1'b0;
            r_s1_a_hi <= '0;
            r_s1_b_hi <= '0;
        end else if (!w_stall) begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_last <= in_last;
                r_s1_lo   <= w_lo_full[SPLIT-1:0];
                r_s1_c    <= w_lo_full[SPLIT];
                r_s1_a_hi <= row_a[IN_W-1:SPLIT];
                r_s1_b_hi <= row_b[IN_W-1:SPLIT];
            end
        end
    end

    // High half wraps at HI_W bits; together with the low half this is the
    // IN_W-bit two's complement sum of the two rows.
    assign w_hi      = r_s1_a_hi + r_s1_b_hi + {{(HI_W-1){1'b0}}, r_s1_c};
    assign w_sum     = {w_hi, r_s1_lo};
    assign w_sum_ext = {{(ACC_W-IN_W){w_sum[IN_W-1]}}, w_sum};

    // Add in the wide type so the true sum is visible before clamping.
    assign w_acc_add = calc_t'(r_acc) + calc_t'(w_sum_ext);
    assign w_acc_sat = ACC_W'(sat_val(w_acc_add, ACC_W));
    assign w_sat_hit = sat_hit(w_acc_add, ACC_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_vld   <= 1'b0;
            r_grp_open <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else if (!w_stall) begin
            r_s2_vld <= r_s1_vld & r_s1_last;
            if (r_s1_vld) begin
                if (!r_grp_open) begin
                    // First beat of a group replaces whatever the previous group left.
                    r_acc <= w_sum_ext;
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= w_acc_sat;
                    r_ovf <= r_ovf | w_sat_hit;
                end
                r_grp_open <= ~r_s1_last;
            end
        end
    end

    // S3 reads r_acc in the cycle after the last beat; if the next group's
    // first beat lands in S2 on that same edge, the non-blocking update means
    // requant still sees the finished value.
    addertree_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .i_acc   (r_acc),
        .i_shift (cfg_shift),
        .o_data  (w_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (!w_stall) begin
            // Not stalled means either nothing is shown or it is being taken
            // this cycle, so the register is free to take the next result.
            r_out_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_out_data <= w_q;
                r_out_ovf  <= r_ovf;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign busy      = r_s1_vld | r_s2_vld | r_grp_open | r_out_vld;

endmodule
